// File: rtl/bcd_freq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_freq_pkg
// Shared definitions for the BCD frequency meter:
//   BCD_W     - width of one BCD digit
//   state_e   - measurement controller states
//   ch_width  - channel-select width for a given channel count (min 1 bit)
// ---------------------------------------------------------------------------
package bcd_freq_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_GATE   = 2'd1,
        ST_LATCH  = 2'd2
    } state_e;

    // A single channel still needs a one-bit select port.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// ---------------------------------------------------------------------------
// bcd_decade
// One decimal digit of the cascaded BCD counter.
//   clk_in    - clock
//   rst_in    - asynchronous active-high reset
//   clear_in  - synchronous clear to 0 (priority over counting)
//   inc_in    - increment request from the previous decade (or the edge input)
//   sat_in    - freeze the digit (whole counter is at all-9s and saturating)
//   digit_out - current BCD digit
//   nine_out  - digit is 9
//   carry_out - combinational carry into the next decade (inc_in at 9)
// ---------------------------------------------------------------------------
module bcd_decade
    import bcd_freq_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear_in,
    input  logic             inc_in,
    input  logic             sat_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             nine_out,
    output logic             carry_out
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        // NOTE: default assignment first, so every path assigns digit_d and no latch is inferred.
        digit_d = digit_q;
        if (clear_in) begin
            digit_d = '0;
        end else if (inc_in && !sat_in) begin
            digit_d = (digit_q == 4'd9) ? '0 : digit_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_out = digit_q;
    assign nine_out  = (digit_q == 4'd9);
    assign carry_out = inc_in && nine_out;

endmodule

// File: rtl/bcd_freq_meter.sv
// ---------------------------------------------------------------------------
// bcd_freq_meter
// Multi-channel frequency meter: counts synchronized rising edges of one
// selected input during a fixed gate window and latches the BCD count.
//   clk_ref_in       - reference clock, all logic on its rising edge
//   reset_in         - asynchronous active-high reset
//   clk_x_in         - asynchronous signals under measurement
//   ch_sel_in        - channel to measure next when scanning is off
//   scan_en_in       - 1 = step through channels round-robin
//   result_bcd_out   - latched count, digit 0 in bits [3:0]
//   result_ch_out    - channel the latched count belongs to
//   result_ovf_out   - latched count saturated at all-9s
//   result_valid_out - result held and not yet acknowledged
//   result_ack_in    - consumer acknowledge
//   result_lost_out  - sticky: an unacknowledged result was overwritten
// ---------------------------------------------------------------------------
module bcd_freq_meter
    import bcd_freq_pkg::*;
#(
    parameter  int N_CH          = 4,
    parameter  int N_DIGITS      = 6,
    parameter  int GATE_CYCLES   = 10_000_000,
    parameter  int SETTLE_CYCLES = 3,
    localparam int CH_W          = ch_width(N_CH)
) (
    input  logic                      clk_ref_in,
    input  logic                      reset_in,
    input  logic [N_CH-1:0]           clk_x_in,
    input  logic [CH_W-1:0]           ch_sel_in,
    input  logic                      scan_en_in,
    output logic [BCD_W*N_DIGITS-1:0] result_bcd_out,
    output logic [CH_W-1:0]           result_ch_out,
    output logic                      result_ovf_out,
    output logic                      result_valid_out,
    input  logic                      result_ack_in,
    output logic                      result_lost_out
);

    // One shared timer serves both SETTLE and GATE; it counts 0..len-1.
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

    // ---------------- input synchronizers and edge detect ----------------
    logic [N_CH-1:0] sync1_q, sync2_q, hist_q;
    logic [N_CH-1:0] rise_vec;
    logic            edge_sel;

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= clk_x_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_vec = sync2_q & ~hist_q;

    // ---------------- controller ----------------
    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    // Loop mux keeps the index in range for any N_CH / CH_W combination.
    always_comb begin
        edge_sel = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == CH_W'(i)) edge_sel = rise_vec[i];
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TMR_W'(1);
        ch_d    = ch_q;
        case (state_q)
            ST_SETTLE: if (timer_q == SETTLE_LAST) begin
                state_d = ST_GATE;
                timer_d = '0;
            end
            ST_GATE: if (timer_q == GATE_LAST) begin
                state_d = ST_LATCH;
                timer_d = '0;
            end
            ST_LATCH: begin
                state_d = ST_SETTLE;
                timer_d = '0;
                // Channel inputs are only looked at here, so mid-measurement
                // changes never disturb the window in progress.
                if (scan_en_in) begin
                    ch_d = (int'(ch_q) == N_CH - 1) ? '0 : ch_q + CH_W'(1);
                end else begin
                    ch_d = (int'(ch_sel_in) >= N_CH) ? '0 : ch_sel_in;
                end
            end
            default: begin
                state_d = ST_SETTLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_SETTLE;
            timer_q <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ch_q    <= ch_d;
        end
    end

    // ---------------- cascaded BCD counter ----------------
    logic [BCD_W*N_DIGITS-1:0] count_vec;
    logic [N_DIGITS-1:0]       carry;
    logic [N_DIGITS-1:0]       nine;
    logic                      count_en;
    logic                      count_clear;
    logic                      sat_hit;   // edge arrived with every digit at 9
    logic                      ovf_q;

    assign count_en    = (state_q == ST_GATE) && edge_sel;
    assign count_clear = (state_q == ST_SETTLE);
    assign sat_hit     = carry[N_DIGITS-1];

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_decade
        logic inc;
        if (g == 0) begin : g_first
            assign inc = count_en;
        end else begin : g_chain
            assign inc = carry[g-1];
        end
        bcd_decade u_decade (
            .clk_in    (clk_ref_in),
            .rst_in    (reset_in),
            .clear_in  (count_clear),
            .inc_in    (inc),
            .sat_in    (sat_hit),
            .digit_out (count_vec[g*BCD_W +: BCD_W]),
            .nine_out  (nine[g]),
            .carry_out (carry[g])
        );
    end

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            ovf_q <= 1'b0;
        end else if (count_clear) begin
            ovf_q <= 1'b0;
        end else if (sat_hit) begin
            ovf_q <= 1'b1;
        end
    end

    // ---------------- result holding and handshake ----------------
    logic [BCD_W*N_DIGITS-1:0] res_bcd_q, res_bcd_d;
    logic [CH_W-1:0]           res_ch_q, res_ch_d;
    logic                      res_ovf_q, res_ovf_d;
    logic                      valid_q, valid_d;
    logic                      lost_q, lost_d;

    always_comb begin
        res_bcd_d = res_bcd_q;
        res_ch_d  = res_ch_q;
        res_ovf_d = res_ovf_q;
        valid_d   = valid_q;
        lost_d    = lost_q;
        if (state_q == ST_LATCH) begin
            res_bcd_d = count_vec;
            res_ch_d  = ch_q;
            res_ovf_d = ovf_q;
            valid_d   = 1'b1;
            // A same-cycle ack consumes the old result, so nothing is lost.
            if (valid_q) lost_d = !result_ack_in;
        end else if (valid_q && result_ack_in) begin
            valid_d = 1'b0;
            lost_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_ref_in or posedge reset_in) begin
        if (reset_in) begin
            res_bcd_q <= '0;
            res_ch_q  <= '0;
            res_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            res_bcd_q <= res_bcd_d;
            res_ch_q  <= res_ch_d;
            res_ovf_q <= res_ovf_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
        end
    end

    assign result_bcd_out   = res_bcd_q;
    assign result_ch_out    = res_ch_q;
    assign result_ovf_out   = res_ovf_q;
    assign result_valid_out = valid_q;
    assign result_lost_out  = lost_q;

    // Only used through the carry chain; kept visible for debug.
    logic unused_nine;
    assign unused_nine = ^nine;

endmodule

// File: tb/tb_bcd_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_bcd_freq_meter
// Scoreboard bench for bcd_freq_meter. Instance A: N_CH=2, N_DIGITS=3,
// GATE=100, SETTLE=3. Instance B: N_DIGITS=2, GATE=250 (saturation case).
// Stimulus pushes expected results; monitors pop on each valid rise.
// ---------------------------------------------------------------------------
module tb_bcd_freq_meter;

    typedef struct {
        logic [11:0] bcd;
        logic        ch;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Free-running test waveforms; toggles sit away from clock edges.
    logic w2, w4, w10;
    initial begin w2  = 1'b0; #4; forever #10 w2  = ~w2;  end
    initial begin w4  = 1'b0; #3; forever #20 w4  = ~w4;  end
    initial begin w10 = 1'b0; #7; forever #50 w10 = ~w10; end

    // ---------------- instance A ----------------
    logic        rst_a, sel_a, scan_a, man_ack, auto_ack;
    logic [1:0]  x_a;
    logic [11:0] bcd_a;
    logic        ch_a, ovf_a, valid_a, ack_a, lost_a;

    assign x_a   = {w10, w4};
    assign ack_a = man_ack | (auto_ack & valid_a);

    bcd_freq_meter #(.N_CH(2), .N_DIGITS(3), .GATE_CYCLES(100), .SETTLE_CYCLES(3)) dut_a (
        .clk_ref_in       (clk),
        .reset_in         (rst_a),
        .clk_x_in         (x_a),
        .ch_sel_in        (sel_a),
        .scan_en_in       (scan_a),
        .result_bcd_out   (bcd_a),
        .result_ch_out    (ch_a),
        .result_ovf_out   (ovf_a),
        .result_valid_out (valid_a),
        .result_ack_in    (ack_a),
        .result_lost_out  (lost_a)
    );

    // ---------------- instance B ----------------
    logic       rst_b, sel_b, scan_b, ack_b;
    logic [1:0] x_b;
    logic [7:0] bcd_b;
    logic       ch_b, ovf_b, valid_b, lost_b;

    assign x_b = {1'b0, w2};

    bcd_freq_meter #(.N_CH(2), .N_DIGITS(2), .GATE_CYCLES(250), .SETTLE_CYCLES(3)) dut_b (
        .clk_ref_in       (clk),
        .reset_in         (rst_b),
        .clk_x_in         (x_b),
        .ch_sel_in        (sel_b),
        .scan_en_in       (scan_b),
        .result_bcd_out   (bcd_b),
        .result_ch_out    (ch_b),
        .result_ovf_out   (ovf_b),
        .result_valid_out (valid_b),
        .result_ack_in    (ack_b),
        .result_lost_out  (lost_b)
    );

    // Cycles since reset release (value after the n-th rising edge is n).
    int cyc_a, cyc_b;
    always @(posedge clk or posedge rst_a) if (rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboards and monitors ----------------
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic vprev_a = 1'b0;
    logic vprev_b = 1'b0;

    always @(negedge clk) begin
        if (rst_a) begin
            vprev_a = 1'b0;
        end else begin
            if (valid_a && !vprev_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_result", 32'(bcd_a), 32'hFFFF_FFFF);
                end else begin
                    ea = q_a.pop_front();
                    check("a_bcd", 32'(bcd_a), 32'(ea.bcd));
                    check("a_ch",  32'(ch_a),  32'(ea.ch));
                    check("a_ovf", 32'(ovf_a), 32'(ea.ovf));
                    check("a_cyc", 32'(cyc_a), 32'(ea.cyc));
                end
            end
            vprev_a = valid_a;
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            vprev_b = 1'b0;
        end else begin
            if (valid_b && !vprev_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_result", 32'(bcd_b), 32'hFFFF_FFFF);
                end else begin
                    eb = q_b.pop_front();
                    check("b_bcd", 32'(bcd_b), 32'(eb.bcd));
                    check("b_ch",  32'(ch_b),  32'(eb.ch));
                    check("b_ovf", 32'(ovf_b), 32'(eb.ovf));
                    check("b_cyc", 32'(cyc_b), 32'(eb.cyc));
                end
            end
            vprev_b = valid_b;
        end
    end

    // ---------------- helpers ----------------
    task automatic push_a(input logic [11:0] bcd, input logic ch, input logic ovf, input int cyc);
        exp_t e;
        e.bcd = bcd; e.ch = ch; e.ovf = ovf; e.cyc = cyc;
        q_a.push_back(e);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        q_a.delete();
    endtask

    task automatic release_a();
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic wait_cyc_a(input int n);
        while (cyc_a < n) @(negedge clk);
    endtask

    task automatic drain_a(input int budget);
        int n;
        n = 0;
        while (q_a.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0) begin
            check("a_result_timeout", 32'(q_a.size()), 32'd0);
            q_a.delete();
        end
    endtask

    task automatic drain_b(input int budget);
        int n;
        n = 0;
        while (q_b.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q_b.size() != 0) begin
            check("b_result_timeout", 32'(q_b.size()), 32'd0);
            q_b.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        rst_a = 1'b1; sel_a = 1'b0; scan_a = 1'b0; man_ack = 1'b0; auto_ack = 1'b0;
        rst_b = 1'b1; sel_b = 1'b0; scan_b = 1'b0; ack_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_bcd",   32'(bcd_a),   32'd0);
        check("rst_ch",    32'(ch_a),    32'd0);
        check("rst_ovf",   32'(ovf_a),   32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_lost",  32'(lost_a),  32'd0);
        check("rst_b_bcd", 32'(bcd_b),   32'd0);

        // Fixed channel 0, period 4: 25 edges per 100-cycle gate, period 104
        auto_ack = 1'b1;
        release_a();
        push_a(12'h025, 1'b0, 1'b0, 104);
        push_a(12'h025, 1'b0, 1'b0, 208);
        drain_a(260);

        // Round-robin scan: ch0 (period 4) then ch1 (period 10) then ch0
        reset_a();
        scan_a = 1'b1;
        release_a();
        push_a(12'h025, 1'b0, 1'b0, 104);
        push_a(12'h010, 1'b1, 1'b0, 208);
        push_a(12'h025, 1'b0, 1'b0, 312);
        drain_a(360);
        scan_a = 1'b0;

        // No ack: second result overwrites first and sets lost.
        // ch_sel change mid-gate must not affect the current window.
        reset_a();
        auto_ack = 1'b0;
        sel_a = 1'b0;
        release_a();
        push_a(12'h025, 1'b0, 1'b0, 104);
        wait_cyc_a(50);
        sel_a = 1'b1;
        drain_a(150);
        wait_cyc_a(150);
        check("lost_before_overwrite", 32'(lost_a), 32'd0);
        wait_cyc_a(209);
        check("ovr_valid", 32'(valid_a), 32'd1);
        check("ovr_lost",  32'(lost_a),  32'd1);
        check("ovr_bcd",   32'(bcd_a),   32'h010);
        check("ovr_ch",    32'(ch_a),    32'd1);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("ack_clears_valid", 32'(valid_a), 32'd0);
        check("ack_clears_lost",  32'(lost_a),  32'd0);

        // Ack in the same cycle as LATCH: new data, valid held, no loss
        reset_a();
        sel_a = 1'b0;
        release_a();
        push_a(12'h025, 1'b0, 1'b0, 104);
        drain_a(150);
        wait_cyc_a(207);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("latch_ack_cyc",   32'(cyc_a),   32'd208);
        check("latch_ack_valid", 32'(valid_a), 32'd1);
        check("latch_ack_lost",  32'(lost_a),  32'd0);
        check("latch_ack_bcd",   32'(bcd_a),   32'h025);
        @(negedge clk);
        check("latch_ack_hold",  32'(valid_a), 32'd1);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("final_ack_valid", 32'(valid_a), 32'd0);

        // Reset at gate cycle 50: partial count dropped, fresh 104-cycle latency
        reset_a();
        release_a();
        wait_cyc_a(53);
        rst_a = 1'b1;
        @(negedge clk);
        check("midgate_rst_valid", 32'(valid_a), 32'd0);
        check("midgate_rst_bcd",   32'(bcd_a),   32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        push_a(12'h025, 1'b0, 1'b0, 104);
        drain_a(150);

        // Saturation: period 2 over 250 cycles = 125 edges > 99
        @(negedge clk);
        rst_b = 1'b0;
        e.bcd = 12'h099; e.ch = 1'b0; e.ovf = 1'b1; e.cyc = 254;
        q_b.push_back(e);
        drain_b(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
